ppu_pixel_fifo: RTL

PPU_PIXEL_FIFO -- requirements
Module: ppu_pixel_fifo

---
 rtl/ppu_pixel_fifo.sv | 117 +++++++++++
 1 files changed

// File: rtl/ppu_pixel_fifo.sv
`default_nettype none
// ============================================================================
// ppu_pixel_fifo : show-ahead pixel FIFO filled one 8-pixel tile row at a time
//                  and drained per pixel, with fine-scroll discard.  Rev 1.0
// ============================================================================
module ppu_pixel_fifo #(
    parameter int DEPTH  = 16,
    parameter int ATTR_W = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load,
    input  logic [7:0]                   plane0,
    input  logic [7:0]                   plane1,
    input  logic [ATTR_W-1:0]            attr,
    input  logic                         flip_x,
    input  logic                         pop,
    input  logic                         discard,
    input  logic [2:0]                   discard_cnt,
    input  logic                         flush,
    output logic                         load_ready,
    output logic                         px_valid,
    output logic [1:0]                   px_color,
    output logic [ATTR_W-1:0]            px_attr,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int EW = 2 + ATTR_W;

    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d, underflow_q, underflow_d;
    logic          load_ok;
    logic [CW-1:0] removed;
    logic [EW-1:0] row [8];
    logic [EW-1:0] head;

    assign load_ready = (count_q <= CW'(DEPTH - 8));

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            row[i] = flip_x ? {plane1[i], plane0[i], attr}
                            : {plane1[3'(7 - i)], plane0[3'(7 - i)], attr};
        end
    end

    always_comb begin
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        load_ok     = 1'b0;
        removed     = '0;
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            load_ok = load && load_ready;
            if (load && !load_ready) overflow_d = 1'b1;
            // Discard takes precedence and silently swallows a same-cycle pop.
            if (discard) begin
                removed = (CW'(discard_cnt) < count_q) ? CW'(discard_cnt) : count_q;
            end else if (pop) begin
                if (count_q != '0) removed = CW'(1);
                else               underflow_d = 1'b1;
            end
            rd_ptr_d = rd_ptr_q + PW'(removed);
            wr_ptr_d = wr_ptr_q + (load_ok ? PW'(8) : PW'(0));
            count_d  = count_q + (load_ok ? CW'(8) : CW'(0)) - removed;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load_ok) begin
            for (int i = 0; i < 8; i++) begin
                mem_q[wr_ptr_q + PW'(i)] <= row[i];
            end
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign px_valid  = !empty;
    assign px_color  = empty ? 2'b00 : head[EW-1 -: 2];
    assign px_attr   = empty ? '0 : head[ATTR_W-1:0];
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule
`default_nettype wire
